ov7670_config_sequencer: RTL and testbench
==========================================

OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

Interface
REQ-001 SHALL have parameter DELAY_CYCLES, default 1_000_000, cycles waited per delay entry (10 ms at 100 MHz).
REQ-002 SHALL have parameter LAST_ADDR, default 8'hFF, highest ROM address processed.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a configuration pass.
REQ-006 SHALL have port rom_addr  output  8  address to the OV7670 config ROM.
REQ-007 SHALL have port rom_dout  input  16  ROM entry: [15:8] register address, [7:0] register data.
REQ-008 SHALL have port wr_valid  output  1  register-write request to the downstream SCCB writer.
REQ-009 SHALL have port wr_reg_addr  output  8  register address for the request.
REQ-010 SHALL have port wr_reg_data  output  8  register data for the request.
REQ-011 SHALL have port wr_ready  input  1  SCCB writer idle and able to accept a request.
REQ-012 SHALL have port busy  output  1  high while a pass is in progress.
REQ-013 SHALL have port done  output  1  high from pass completion until the next start or reset.

Function
REQ-014 SHALL use states IDLE, FETCH, DECODE, SEND, DELAY, DONE.
REQ-015 The ROM SHALL be treated as synchronous: rom_dout is valid one cycle after rom_addr changes; FETCH lasts exactly one cycle, and DECODE samples rom_dout.
REQ-016 IDLE or DONE with start=1 SHALL set rom_addr=0 and done=0, and go to FETCH next cycle.
REQ-017 start SHALL be ignored in FETCH, DECODE, SEND and DELAY.
REQ-018 DECODE entry 16'hFFFF (end marker) SHALL go to DONE.
REQ-019 DECODE entry 16'hFFF0 (delay marker) SHALL load the delay counter with DELAY_CYCLES-1 and go to DELAY.
REQ-020 DECODE with any other entry SHALL latch wr_reg_addr=rom_dout[15:8] and wr_reg_data=rom_dout[7:0], and go to SEND.
REQ-021 SEND SHALL hold wr_valid=1, with wr_reg_addr and wr_reg_data stable, until a cycle with wr_valid&&wr_ready; that cycle is the handshake.
REQ-022 wr_valid SHALL fall in the cycle after the handshake; it SHALL never be high outside SEND.
REQ-023 DELAY SHALL decrement the counter each cycle, leaving when it reaches 0, for exactly DELAY_CYCLES cycles in DELAY.
REQ-024 After a handshake or a completed delay: if rom_addr==LAST_ADDR, SHALL go to DONE (no wrap to 0); else SHALL increment rom_addr and go to FETCH.
REQ-025 busy SHALL be 1 in FETCH, DECODE, SEND and DELAY, and 0 in IDLE and DONE.
REQ-026 done SHALL be registered, set on entering DONE, and held until start or reset.
REQ-027 The delay counter SHALL be $clog2(DELAY_CYCLES+1) bits wide; rom_addr SHALL be 8 bits unsigned.
REQ-028 A DELAY_CYCLES value of 0 SHALL be treated as 1.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, rom_addr=0, wr_valid=0, wr_reg_addr=0, wr_reg_data=0, busy=0, done=0, and delay counter=0.
REQ-030 reset SHALL take priority over start and over any handshake in the same cycle.
REQ-031 reset asserted mid-pass (including in SEND with wr_valid=1) SHALL drop wr_valid on the next cycle and require a new start.

Verification
REQ-032 ROM {0x1280, 0x1101, 0xFFFF}, wr_ready=1, start pulse -> exactly two handshakes (0x12/0x80, then 0x11/0x01); done=1 and busy=0 afterwards; rom_addr stops at 2.
REQ-033 ROM {0x1280, ...}, wr_ready held 0 for 20 cycles then 1 -> wr_valid high and 0x12/0x80 stable for all 20 cycles; one handshake; wr_valid low the next cycle.
REQ-034 DELAY_CYCLES=5, ROM {0xFFF0, 0x3A04, 0xFFFF} -> exactly 5 cycles in DELAY, then the 0x3A/0x04 handshake, then done.
REQ-035 ROM with no end marker, LAST_ADDR=3, 4 normal entries -> 4 handshakes, done=1, and rom_addr never exceeds 3.
REQ-036 reset asserted while in SEND with wr_ready=0 -> next cycle wr_valid=0, busy=0, done=0, rom_addr=0; a later start restarts from entry 0.
REQ-037 start pulses during SEND, and again after done -> first pulse ignored (no restart); second pulse clears done and replays the ROM from address 0.

Source files
------------

// File: rtl/ov7670_config_sequencer.sv
// OV7670 configuration sequencer.
// Walks a synchronous config ROM from address 0 and issues one register write
// per entry to a downstream SCCB writer through a valid/ready handshake.
// 16'hFFFF ends the pass, and 16'hFFF0 inserts a DELAY_CYCLES-cycle pause.
// The pass also ends after the entry at LAST_ADDR.
// Ports:
//   clk, reset      - rising-edge clock; synchronous active-high reset
//   start           - one-cycle pulse; begins a pass from IDLE or DONE
//   rom_addr        - ROM address (8 bits); rom_dout is valid one cycle later
//   rom_dout        - ROM entry {register address, register data}
//   wr_valid        - write request, held until accepted
//   wr_reg_addr/data - payload of the pending write request
//   wr_ready        - writer can accept a request
//   busy            - pass in progress
//   done            - pass finished; held until start or reset
module ov7670_config_sequencer #(
   parameter int unsigned DELAY_CYCLES = 1_000_000,
   parameter logic [7:0]  LAST_ADDR    = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  rom_addr,
   input  logic [15:0] rom_dout,
   output logic        wr_valid,
   output logic [7:0]  wr_reg_addr,
   output logic [7:0]  wr_reg_data,
   input  logic        wr_ready,
   output logic        busy,
   output logic        done
);

   // A zero delay request still spends one cycle in DELAY
   localparam int unsigned DELAY_EFF = (DELAY_CYCLES == 0) ? 1 : DELAY_CYCLES;
   localparam int unsigned CNT_W     = $clog2(DELAY_EFF + 1);
   localparam logic [15:0] END_MARK   = 16'hFFFF;
   localparam logic [15:0] DELAY_MARK = 16'hFFF0;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, DELAY, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] delay_cnt;
   logic             last_entry_c;

   assign last_entry_c = (rom_addr == LAST_ADDR);

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rom_addr    <= 8'd0;
         wr_valid    <= 1'b0;
         wr_reg_addr <= 8'd0;
         wr_reg_data <= 8'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         delay_cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  rom_addr <= 8'd0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  state    <= FETCH;
               end
            end
            // ROM registers rom_addr during this cycle
            FETCH: state <= DECODE;
            DECODE: begin
               if (rom_dout == END_MARK) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (rom_dout == DELAY_MARK) begin
                  delay_cnt <= CNT_W'(DELAY_EFF - 1);
                  state     <= DELAY;
               end else begin
                  wr_reg_addr <= rom_dout[15:8];
                  wr_reg_data <= rom_dout[7:0];
                  wr_valid    <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: begin
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  if (last_entry_c) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= FETCH;
                  end
               end
            end
            // Counter runs DELAY_EFF-1 down to 0: DELAY_EFF cycles here
            DELAY: begin
               if (delay_cnt == '0) begin
                  if (last_entry_c) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     rom_addr <= rom_addr + 8'd1;
                     state    <= FETCH;
                  end
               end else begin
                  delay_cnt <= delay_cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Testbench for ov7670_config_sequencer (DELAY_CYCLES=5, LAST_ADDR=3).
// Table-driven ROM programs, hand-written stall/restart/reset sequences and
// random programs, all checked against a behavioural model of the pass.
module tb_ov7670_config_sequencer;

   localparam int unsigned DC   = 5;
   localparam logic [7:0]  LAST = 8'h03;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        wr_valid;
   logic [7:0]  wr_reg_addr;
   logic [7:0]  wr_reg_data;
   logic        wr_ready;
   logic        busy;
   logic        done;

   logic        rdy_mode;   // 0: rdy_man drives wr_ready, 1: random
   logic        rdy_man;
   logic        rdy_rand;
   logic        mon_en;

   logic [15:0] rom_mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   ov7670_config_sequencer #(.DELAY_CYCLES(DC), .LAST_ADDR(LAST)) dut (
      .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
      .rom_dout(rom_dout), .wr_valid(wr_valid), .wr_reg_addr(wr_reg_addr),
      .wr_reg_data(wr_reg_data), .wr_ready(wr_ready), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: one cycle of read latency
   always @(posedge clk) rom_dout <= rom_mem[rom_addr];

   always @(posedge clk) begin
      #1;
      rdy_rand = 1'($urandom);
   end

   assign wr_ready = rdy_mode ? rdy_rand : rdy_man;

   // Protocol monitor: records handshakes, busy/stall cycles, violations
   logic [15:0] obs_q [$];
   int          busy_cnt  = 0;
   int          stall_cnt = 0;
   int          viol      = 0;
   bit          hold_prev = 0;
   bit          hs_prev   = 0;
   logic [15:0] h_word    = 16'd0;

   always @(negedge clk) begin
      if (!mon_en) begin
         hold_prev = 0;
         hs_prev   = 0;
      end else begin
         if (hold_prev && !(wr_valid && {wr_reg_addr, wr_reg_data} == h_word)) viol++;
         if (hs_prev && wr_valid) viol++;
         if (wr_valid && !busy) viol++;
         if (busy) busy_cnt++;
         hold_prev = wr_valid && !wr_ready;
         h_word    = {wr_reg_addr, wr_reg_data};
         if (hold_prev) stall_cnt++;
         hs_prev = wr_valid && wr_ready;
         if (hs_prev) obs_q.push_back({wr_reg_addr, wr_reg_data});
      end
   end

   typedef struct packed {
      logic [5:0][15:0] prog;       // prog[0] is ROM address 0
      logic [7:0]       exp_writes;
      logic [7:0]       exp_busy;   // busy cycles with wr_ready held high
      logic [7:0]       exp_fin;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input bit ok, input string nm, input longint act, input longint exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_rom(input logic [5:0][15:0] prog);
      for (int i = 0; i < 256; i++) rom_mem[i] = (i < 6) ? prog[i] : 16'hA5A5;
   endtask

   // Expected pass from the ROM contents: writes in order, busy cycles
   // excluding stalls (2 per entry fetched, +1 per write, +DC per delay),
   // and the address the pass stops on.
   function automatic void model(output logic [15:0] q[$], output int base,
                                 output logic [7:0] fin);
      int a;
      logic [15:0] e;
      a = 0;
      base = 0;
      q = {};
      while (1) begin
         e = rom_mem[a];
         base += 2;
         if (e == 16'hFFFF) break;
         if (e == 16'hFFF0) base += DC;
         else begin
            q.push_back(e);
            base += 1;
         end
         if (a == int'(LAST)) break;
         a++;
      end
      fin = 8'(a);
   endfunction

   task automatic wait_done(input int budget, output logic [7:0] maxa);
      bit seen;
      seen = 0;
      maxa = rom_addr;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) seen = 1;
         else begin
            tick();
            if (rom_addr > maxa) maxa = rom_addr;
         end
      end
      check(seen, "pass_done", longint'(done), 1);
   endtask

   // mode 0: plain pass; 1: wr_ready low for 20 SEND cycles; 2: start pulse during SEND
   task automatic do_pass(input int mode, input int ew, input int eb, input logic [7:0] efin);
      logic [15:0] exp_q [$];
      int base, n, st, hs0, b0, s0, v0;
      logic [7:0] fin, maxa;
      model(exp_q, base, fin);
      hs0 = obs_q.size();
      b0  = busy_cnt;
      s0  = stall_cnt;
      v0  = viol;
      if (mode != 0) rdy_man = 1'b0;
      pulse_start();
      check(!done && busy && rom_addr == 8'd0, "start_clears",
            longint'({done, busy, rom_addr}), longint'({1'b0, 1'b1, 8'd0}));
      if (mode != 0) begin
         for (int i = 0; i < 10 && !wr_valid; i++) tick();
         check(wr_valid, "send_reached", longint'(wr_valid), 1);
         if (mode == 1) begin
            for (int k = 0; k < 20; k++) begin
               check(wr_valid && wr_reg_addr == 8'h12 && wr_reg_data == 8'h80, "stall_hold",
                     longint'({wr_valid, wr_reg_addr, wr_reg_data}), longint'(17'h11280));
               tick();
            end
            rdy_man = 1'b1;
            tick();
            check(!wr_valid, "valid_fall", longint'(wr_valid), 0);
         end else begin
            start = 1'b1;
            tick();
            start = 1'b0;
            check(wr_valid && busy && rom_addr == 8'd0, "start_ignored",
                  longint'({wr_valid, busy, rom_addr}), longint'({1'b1, 1'b1, 8'd0}));
            rdy_man = 1'b1;
         end
      end
      wait_done(2000, maxa);
      n  = obs_q.size() - hs0;
      st = stall_cnt - s0;
      check(n == exp_q.size(), "hs_count", n, exp_q.size());
      for (int i = 0; i < n && i < exp_q.size(); i++)
         check(obs_q[hs0 + i] == exp_q[i], "hs_word", longint'(obs_q[hs0 + i]), longint'(exp_q[i]));
      check(busy_cnt - b0 == base + st, "busy_cycles", busy_cnt - b0, base + st);
      check(rom_addr == fin, "final_addr", longint'(rom_addr), longint'(fin));
      check(maxa == fin, "max_addr", longint'(maxa), longint'(fin));
      check(!busy && !wr_valid && done, "done_state",
            longint'({busy, wr_valid, done}), 1);
      check(viol == v0, "protocol", viol - v0, 0);
      if (mode == 1) check(st == 20, "stall_cycles", st, 20);
      if (ew >= 0) begin
         check(n == ew, "tbl_writes", n, ew);
         check(busy_cnt - b0 - st == eb, "tbl_busy", busy_cnt - b0 - st, eb);
         check(rom_addr == efin, "tbl_final", longint'(rom_addr), longint'(efin));
      end
   endtask

   initial begin
      logic [5:0][15:0] p;
      vecs[0] = '{prog: {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16'h1101, 16'h1280},
                  exp_writes: 8'd2, exp_busy: 8'd8,  exp_fin: 8'd2};
      vecs[1] = '{prog: {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16'h3A04, 16'hFFF0},
                  exp_writes: 8'd1, exp_busy: 8'd12, exp_fin: 8'd2};
      vecs[2] = '{prog: {16'hA5A5, 16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001},
                  exp_writes: 8'd4, exp_busy: 8'd12, exp_fin: 8'd3};
      vecs[3] = '{prog: {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF},
                  exp_writes: 8'd0, exp_busy: 8'd2,  exp_fin: 8'd0};
      vecs[4] = '{prog: {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16'hFFF0, 16'hFFF0},
                  exp_writes: 8'd0, exp_busy: 8'd16, exp_fin: 8'd2};
      vecs[5] = '{prog: {16'hA5A5, 16'h5555, 16'hFFF0, 16'h0304, 16'hFFF0, 16'h0102},
                  exp_writes: 8'd2, exp_busy: 8'd20, exp_fin: 8'd3};

      reset    = 1'b1;
      start    = 1'b0;
      rdy_mode = 1'b0;
      rdy_man  = 1'b1;
      mon_en   = 1'b0;
      load_rom(vecs[3].prog);
      repeat (3) tick();
      check(rom_addr == 8'd0, "rst_rom_addr", longint'(rom_addr), 0);
      check(!wr_valid, "rst_wr_valid", longint'(wr_valid), 0);
      check(wr_reg_addr == 8'd0, "rst_reg_addr", longint'(wr_reg_addr), 0);
      check(wr_reg_data == 8'd0, "rst_reg_data", longint'(wr_reg_data), 0);
      check(!busy, "rst_busy", longint'(busy), 0);
      check(!done, "rst_done", longint'(done), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      tick();

      for (int v = 0; v < 6; v++) begin
         load_rom(vecs[v].prog);
         do_pass(0, int'(vecs[v].exp_writes), int'(vecs[v].exp_busy), vecs[v].exp_fin);
      end

      // Long back-pressure on the first write
      p = {16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16'h1280};
      load_rom(p);
      do_pass(1, 1, 5, 8'd1);

      // start during SEND is ignored; start after done replays from 0
      load_rom(vecs[0].prog);
      do_pass(2, 2, 8, 8'd2);
      rdy_man = 1'b1;
      do_pass(0, 2, 8, 8'd2);

      // Reset in SEND wins over a simultaneous handshake
      rdy_man = 1'b0;
      pulse_start();
      for (int i = 0; i < 10 && !wr_valid; i++) tick();
      check(wr_valid, "pre_reset_send", longint'(wr_valid), 1);
      mon_en  = 1'b0;
      rdy_man = 1'b1;
      reset   = 1'b1;
      tick();
      reset = 1'b0;
      check(!wr_valid && !busy && !done, "rst_mid_flags",
            longint'({wr_valid, busy, done}), 0);
      check(rom_addr == 8'd0 && wr_reg_addr == 8'd0, "rst_mid_addr",
            longint'({rom_addr, wr_reg_addr}), 0);
      repeat (3) tick();
      check(!busy && !wr_valid, "rst_needs_start", longint'({busy, wr_valid}), 0);
      mon_en = 1'b1;
      do_pass(0, 2, 8, 8'd2);

      // Random programs, ready either steady or random
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < 6; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) p[i] = 16'hFFFF;
            else if (sel <= 2) p[i] = 16'hFFF0;
            else p[i] = 16'($urandom) & 16'h7FFF;
         end
         load_rom(p);
         rdy_mode = 1'(r % 2);
         rdy_man  = 1'b1;
         do_pass(0, -1, 0, 8'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
